uart_echo_top: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx.sv | 105 ++++++++++
 rtl/uart_tx.sv | 94 +++++++++
 rtl/uart_echo_top.sv | 82 ++++++++
 tb/tb_uart_echo_top.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo datapath.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling, framing-error recovery.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   logic                 sync1;
   logic                 sync2;
   logic                 prev;
   logic                 fall;
   rx_state_t            state;
   rx_state_t            state_d;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_d;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_idx_d;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_d;
   logic                 valid_d;

   assign fall = prev & ~sync2;
   assign data = shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         prev    <= 1'b1;
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         valid   <= 1'b0;
      end else begin
         sync1   <= rx;
         sync2   <= sync1;
         prev    <= sync2;
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
         valid   <= valid_d;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt + 1'b1;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      valid_d   = 1'b0;
      unique case (state)
         RX_IDLE: begin
            cnt_d = '0;
            if (fall) state_d = RX_START;
         end
         RX_START: begin
            // Half a bit in: a line that has gone high again was a glitch.
            if (cnt == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {sync2, shift[DATA_BITS-1:1]};
               if (bit_idx == BIT_LAST) state_d = RX_STOP;
               else bit_idx_d = bit_idx + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_d = '0;
               if (sync2) begin
                  valid_d = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_WAIT_HIGH;
               end
            end
         end
         RX_WAIT_HIGH: begin
            cnt_d = '0;
            if (sync2) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; accepts the next byte in the last stop-bit cycle
// so frames can run back to back with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 start,
   output logic                 busy,
   output logic                 tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   tx_state_t            state;
   tx_state_t            state_d;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_d;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_idx_d;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_d;
   logic                 line_d;
   logic                 last;

   assign last = cnt == CNT_LAST;
   assign busy = ~((state == TX_IDLE) | ((state == TX_STOP) & last));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
         tx      <= line_d;
      end
   end

   // The line is registered, so it trails the state by one cycle.
   always_comb begin
      state_d   = state;
      cnt_d     = last ? '0 : cnt + 1'b1;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      line_d    = 1'b1;
      unique case (state)
         TX_IDLE: begin
            cnt_d = '0;
            if (start) begin
               shift_d = data;
               state_d = TX_START;
            end
         end
         TX_START: begin
            line_d = 1'b0;
            if (last) begin
               bit_idx_d = '0;
               state_d   = TX_DATA;
            end
         end
         TX_DATA: begin
            line_d = shift[0];
            if (last) begin
               shift_d = shift >> 1;
               if (bit_idx == BIT_LAST) state_d = TX_STOP;
               else bit_idx_d = bit_idx + 1'b1;
            end
         end
         TX_STOP: begin
            if (last) begin
               if (start) begin
                  shift_d = data;
                  state_d = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_echo_top.sv
// IceStick UART loopback: rx -> 4-entry FIFO -> tx, led1 toggles
// on every byte accepted into the FIFO.
module uart_echo_top
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 12000000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic hwclk,
   input  logic rst,
   input  logic ftdi_rx,
   output logic ftdi_tx,
   output logic led1
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH = FIFO_DEPTH[PTR_W:0];

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 tx_busy;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] head;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;

   assign full  = count == DEPTH;
   assign empty = count == '0;
   assign pop   = ~empty & ~tx_busy;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push  = rx_valid & (~full | pop);
   assign head  = mem[rd_ptr];

   always_ff @(posedge hwclk) begin
      if (push) mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge hwclk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         led1   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            led1   <= ~led1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop) count <= count + 1'b1;
         else if (pop & ~push) count <= count - 1'b1;
      end
   end

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk  (hwclk),
      .rst  (rst),
      .rx   (ftdi_rx),
      .data (rx_data),
      .valid(rx_valid)
   );

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk  (hwclk),
      .rst  (rst),
      .data (head),
      .start(pop),
      .busy (tx_busy),
      .tx   (ftdi_tx)
   );

endmodule

// File: tb/tb_uart_echo_top.sv
// Directed bench for uart_echo_top at 8 clocks per bit.
module tb_uart_echo_top;

   localparam int CPB = 8;

   logic hwclk = 1'b0;
   logic rst = 1'b1;
   logic ftdi_rx = 1'b1;
   logic ftdi_tx;
   logic led1;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_rx = 0;
   int lows;
   int n;

   logic [7:0] rb [3];
   logic       rstart [3];
   logic       rstop [3];
   int         tf [3];
   bit         rto [3];

   uart_echo_top #(
      .CLK_HZ      (12000000),
      .BAUD        (9600),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .hwclk  (hwclk),
      .rst    (rst),
      .ftdi_rx(ftdi_rx),
      .ftdi_tx(ftdi_tx),
      .led1   (led1)
   );

   always #1 hwclk = ~hwclk;

   always @(posedge hwclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Caller must be at a negedge; returns at a negedge with the line high.
   task automatic send(input logic [7:0] b, input logic stop);
      ftdi_rx = 1'b0;
      t_rx = cyc;
      repeat (CPB) @(negedge hwclk);
      for (int i = 0; i < 8; i++) begin
         ftdi_rx = b[i];
         repeat (CPB) @(negedge hwclk);
      end
      ftdi_rx = stop;
      repeat (CPB) @(negedge hwclk);
      ftdi_rx = 1'b1;
   endtask

   task automatic capture(output logic [7:0] b, output logic st,
                          output logic sp, output int t, output bit to);
      int k;
      k = 0;
      to = 1'b0;
      b = 'x;
      st = 1'bx;
      sp = 1'bx;
      t = 0;
      @(negedge hwclk);
      while (ftdi_tx !== 1'b0 && k < 2000) begin
         @(negedge hwclk);
         k++;
      end
      if (k >= 2000) begin
         to = 1'b1;
      end else begin
         t = cyc;
         repeat (CPB / 2) @(negedge hwclk);
         st = ftdi_tx;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge hwclk);
            b[i] = ftdi_tx;
         end
         repeat (CPB) @(negedge hwclk);
         sp = ftdi_tx;
      end
   endtask

   task automatic watch_idle(input int cycles, output int cnt_low);
      cnt_low = 0;
      repeat (cycles) begin
         @(negedge hwclk);
         if (ftdi_tx !== 1'b1) cnt_low++;
      end
   endtask

   initial begin
      // Reset and idle
      repeat (2) @(negedge hwclk);
      rst = 1'b0;
      check("reset_tx", {31'd0, ftdi_tx}, 32'd1);
      check("reset_led", {31'd0, led1}, 32'd0);
      watch_idle(500, lows);
      check("idle_tx_lows", lows, 0);
      check("idle_led", {31'd0, led1}, 32'd0);

      // Single echo of 0x55 with latency check
      fork
         send(8'h55, 1'b1);
         capture(rb[0], rstart[0], rstop[0], tf[0], rto[0]);
      join
      check("single_timeout", {31'd0, rto[0]}, 32'd0);
      check("single_start", {31'd0, rstart[0]}, 32'd0);
      check("single_byte", {24'd0, rb[0]}, 32'h55);
      check("single_stop", {31'd0, rstop[0]}, 32'd1);
      check("single_latency", tf[0] - t_rx, 82);
      check("single_led", {31'd0, led1}, 32'd1);

      // Back-to-back from a fresh reset
      repeat (20) @(negedge hwclk);
      rst = 1'b1;
      repeat (2) @(negedge hwclk);
      rst = 1'b0;
      check("b2b_reset_led", {31'd0, led1}, 32'd0);
      fork
         begin
            send(8'h00, 1'b1);
            send(8'hFF, 1'b1);
            send(8'hA5, 1'b1);
         end
         begin
            capture(rb[0], rstart[0], rstop[0], tf[0], rto[0]);
            capture(rb[1], rstart[1], rstop[1], tf[1], rto[1]);
            capture(rb[2], rstart[2], rstop[2], tf[2], rto[2]);
         end
      join
      check("b2b0_timeout", {31'd0, rto[0]}, 32'd0);
      check("b2b0_byte", {24'd0, rb[0]}, 32'h00);
      check("b2b0_stop", {31'd0, rstop[0]}, 32'd1);
      check("b2b1_timeout", {31'd0, rto[1]}, 32'd0);
      check("b2b1_byte", {24'd0, rb[1]}, 32'hFF);
      check("b2b1_start", {31'd0, rstart[1]}, 32'd0);
      check("b2b2_timeout", {31'd0, rto[2]}, 32'd0);
      check("b2b2_byte", {24'd0, rb[2]}, 32'hA5);
      check("b2b2_stop", {31'd0, rstop[2]}, 32'd1);
      check("b2b_gap01", tf[1] - tf[0], 80);
      check("b2b_gap12", tf[2] - tf[1], 80);
      check("b2b_led", {31'd0, led1}, 32'd1);

      // Framing error then a good frame
      repeat (20) @(negedge hwclk);
      send(8'h3C, 1'b0);
      watch_idle(120, lows);
      check("frame_err_tx_lows", lows, 0);
      check("frame_err_led", {31'd0, led1}, 32'd1);
      fork
         send(8'h3C, 1'b1);
         capture(rb[0], rstart[0], rstop[0], tf[0], rto[0]);
      join
      check("after_err_timeout", {31'd0, rto[0]}, 32'd0);
      check("after_err_byte", {24'd0, rb[0]}, 32'h3C);
      check("after_err_led", {31'd0, led1}, 32'd0);

      // Two-cycle glitch
      repeat (20) @(negedge hwclk);
      ftdi_rx = 1'b0;
      repeat (2) @(negedge hwclk);
      ftdi_rx = 1'b1;
      watch_idle(200, lows);
      check("glitch_tx_lows", lows, 0);
      check("glitch_led", {31'd0, led1}, 32'd0);

      // Reset during the data bits of 0x81
      send(8'h81, 1'b1);
      n = 0;
      while (ftdi_tx !== 1'b0 && n < 200) begin
         @(negedge hwclk);
         n++;
      end
      check("mid_wait_fall", {31'd0, n >= 200}, 32'd0);
      repeat (CPB + 3 * CPB + CPB / 2) @(negedge hwclk);
      check("mid_bit3_low", {31'd0, ftdi_tx}, 32'd0);
      rst = 1'b1;
      @(negedge hwclk);
      check("mid_rst_tx", {31'd0, ftdi_tx}, 32'd1);
      check("mid_rst_fifo", {29'd0, dut.count}, 32'd0);
      check("mid_rst_led", {31'd0, led1}, 32'd0);
      rst = 1'b0;
      watch_idle(300, lows);
      check("mid_rst_tx_lows", lows, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
